// File: rtl/axi_mem_slave.sv
// RAM-backed AXI4 slave: independent read/write burst FSMs over a byte-writable word array.
// Handles FIXED/INCR/WRAP bursts with OKAY/SLVERR/DECERR responses.
package axi_mem_pkg;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awlock;
        logic [3:0]              awcache;
        logic [2:0]              awprot;
        logic [3:0]              awqos;
        logic [3:0]              awregion;
        logic                    awuser;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wuser;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arlock;
        logic [3:0]              arcache;
        logic [2:0]              arprot;
        logic [3:0]              arqos;
        logic [3:0]              arregion;
        logic                    aruser;
        logic                    arvalid;
        logic                    rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_ID_W-1:0]   bid;
        logic [1:0]            bresp;
        logic                  buser;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  ruser;
        logic                  rvalid;
    } s_axi_miso_t;
endpackage

module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned RD_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi,
    output s_axi_miso_t axi_miso,
    output logic        busy_o
);
    localparam int          BYTES = int'(AXI_DATA_W / 8);
    localparam int unsigned LSB   = $clog2(AXI_DATA_W / 8);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;
    typedef enum logic [1:0] {RIdle, RWait, RData} rd_state_e;

    logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [7:0] len);
        logic [31:0] bytes, bnd;
        bytes = 32'd1 << size;
        bnd   = (32'(len) + 32'd1) * bytes;
        case (burst)
            BURST_INCR: return addr + bytes;
            BURST_WRAP: return (addr & ~(bnd - 32'd1)) | ((addr + bytes) & (bnd - 32'd1));
            default:    return addr;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        return (32'(size) > LSB) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic addr_decerr(input logic [31:0] addr);
        return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> LSB) >= MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LSB);
    endfunction

    // ---------------- write path ----------------
    wr_state_e wr_state_q, wr_state_d;
    logic awready_q, awready_d;
    logic [AXI_ID_W-1:0] wid_q, wid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wrem_q, wrem_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic wbad_q, wbad_d, wdec_q, wdec_d, wlerr_q, wlerr_d;
    logic wr_en, w_dec;

    assign w_dec = addr_decerr(waddr_q);

    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wrem_d     = wrem_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wbad_d     = wbad_q;
        wdec_d     = wdec_q;
        wlerr_d    = wlerr_q;
        wr_en      = 1'b0;
        unique case (wr_state_q)
            WIdle: if (awready_q && axi_mosi.awvalid) begin
                wid_d      = axi_mosi.awid;
                waddr_d    = axi_mosi.awaddr;
                wlen_d     = axi_mosi.awlen;
                wrem_d     = axi_mosi.awlen;
                wsize_d    = axi_mosi.awsize;
                wburst_d   = axi_mosi.awburst;
                wbad_d     = burst_bad(axi_mosi.awsize, axi_mosi.awburst, axi_mosi.awlen);
                wdec_d     = 1'b0;
                wlerr_d    = 1'b0;
                wr_state_d = WData;
            end
            WData: if (axi_mosi.wvalid) begin
                wr_en   = !wbad_q && !w_dec;
                wdec_d  = wdec_q | w_dec;
                // The beat count, not wlast, ends the burst; a disagreeing wlast only flags.
                wlerr_d = wlerr_q | (axi_mosi.wlast != (wrem_q == 8'd0));
                waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                wrem_d  = wrem_q - 8'd1;
                if (wrem_q == 8'd0) wr_state_d = WResp;
            end
            WResp: if (axi_mosi.bready) wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
        awready_d = (wr_state_d == WIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= WIdle;
            awready_q  <= 1'b0;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wrem_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wbad_q     <= 1'b0;
            wdec_q     <= 1'b0;
            wlerr_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wrem_q     <= wrem_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            wbad_q     <= wbad_d;
            wdec_q     <= wdec_d;
            wlerr_q    <= wlerr_d;
        end
    end

    // Contents survive reset; nonblocking write gives read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi_mosi.wstrb[b]) mem[widx(waddr_q)][8*b +: 8] <= axi_mosi.wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_e rd_state_q, rd_state_d;
    logic arready_q, arready_d;
    logic [AXI_ID_W-1:0] rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d, ld_addr;
    logic [7:0]  rlen_q, rlen_d, rrem_q, rrem_d;
    logic [2:0]  rsize_q, rsize_d, wcnt_q, wcnt_d;
    logic [1:0]  rburst_q, rburst_d, rresp_q, rresp_d;
    logic rbad_q, rbad_d, rlast_q, rlast_d, ld, ld_last;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rrem_d     = rrem_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rbad_d     = rbad_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        ld         = 1'b0;
        ld_addr    = raddr_q;
        ld_last    = (rrem_q == 8'd0);
        unique case (rd_state_q)
            RIdle: if (arready_q && axi_mosi.arvalid) begin
                rid_d      = axi_mosi.arid;
                raddr_d    = axi_mosi.araddr;
                rlen_d     = axi_mosi.arlen;
                rrem_d     = axi_mosi.arlen;
                rsize_d    = axi_mosi.arsize;
                rburst_d   = axi_mosi.arburst;
                rbad_d     = burst_bad(axi_mosi.arsize, axi_mosi.arburst, axi_mosi.arlen);
                wcnt_d     = 3'(RD_WAIT);
                rd_state_d = RWait;
            end
            RWait: begin
                if (wcnt_q == 3'd0) begin
                    ld         = 1'b1;
                    rd_state_d = RData;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            RData: if (axi_mosi.rready) begin
                if (rlast_q) begin
                    rd_state_d = RIdle;
                end else begin
                    raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                    rrem_d  = rrem_q - 8'd1;
                    if (RD_WAIT == 0) begin
                        ld      = 1'b1;
                        ld_addr = raddr_d;
                        ld_last = (rrem_d == 8'd0);
                    end else begin
                        wcnt_d     = 3'(RD_WAIT - 1);
                        rd_state_d = RWait;
                    end
                end
            end
            default: rd_state_d = RIdle;
        endcase
        if (ld) begin
            rlast_d = ld_last;
            if (addr_decerr(ld_addr)) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else if (rbad_q) begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem[widx(ld_addr)];
            end
        end
        arready_d = (rd_state_d == RIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= RIdle;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rrem_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rbad_q     <= 1'b0;
            wcnt_q     <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rrem_q     <= rrem_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rbad_q     <= rbad_d;
            wcnt_q     <= wcnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    always_comb begin
        axi_miso         = '0;
        axi_miso.awready = awready_q;
        axi_miso.wready  = (wr_state_q == WData);
        axi_miso.bvalid  = (wr_state_q == WResp);
        axi_miso.bid     = wid_q;
        axi_miso.bresp   = wdec_q ? RESP_DECERR : ((wbad_q | wlerr_q) ? RESP_SLVERR : RESP_OKAY);
        axi_miso.arready = arready_q;
        axi_miso.rvalid  = (rd_state_q == RData);
        axi_miso.rid     = rid_q;
        axi_miso.rdata   = rdata_q;
        axi_miso.rresp   = rresp_q;
        axi_miso.rlast   = rlast_q;
    end

    assign busy_o = (wr_state_q != WIdle) | (rd_state_q != RIdle);

    logic unused_mosi;
    assign unused_mosi = ^{axi_mosi.awlock, axi_mosi.awcache, axi_mosi.awprot, axi_mosi.awqos,
                           axi_mosi.awregion, axi_mosi.awuser, axi_mosi.wuser, axi_mosi.arlock,
                           axi_mosi.arcache, axi_mosi.arprot, axi_mosi.arqos, axi_mosi.arregion,
                           axi_mosi.aruser};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: two instances (RD_WAIT=0 and RD_WAIT=2) share one driver;
// expected B/R responses are queued at issue time and checked by a forked monitor.
module tb_axi_mem_slave;
    import axi_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    s_axi_mosi_t drv, mosi, mosi0, mosi1;
    s_axi_miso_t miso, miso0, miso1;
    logic busy0, busy1, busy;
    logic sel = 1'b0;
    logic rready_tb = 1'b1;
    logic rtog = 1'b0;
    int errors = 0;
    int checks = 0;
    int exp_gap = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] wbuf [16];
    logic [31:0] ebuf [16];
    logic [1:0]  erb  [16];

    always_comb begin
        mosi        = drv;
        mosi.rready = rready_tb;
        mosi0       = mosi;
        mosi1       = mosi;
        if (sel) begin
            mosi0.awvalid = 1'b0; mosi0.wvalid = 1'b0; mosi0.arvalid = 1'b0;
        end else begin
            mosi1.awvalid = 1'b0; mosi1.wvalid = 1'b0; mosi1.arvalid = 1'b0;
        end
        miso = sel ? miso1 : miso0;
        busy = sel ? busy1 : busy0;
    end

    axi_mem_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(1024), .RD_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst_n), .axi_mosi(mosi0), .axi_miso(miso0), .busy_o(busy0));
    axi_mem_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(1024), .RD_WAIT(2)) u_dut1 (
        .clk(clk), .rst(rst_n), .axi_mosi(mosi1), .axi_miso(miso1), .busy_o(busy1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting, got none expected handshake", name);
    endtask

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return miso.awready;
            1:       return miso.wready;
            default: return miso.arready;
        endcase
    endfunction

    task automatic hs_wait(input int ch);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rdy(ch)) break;
            n++;
            if (n > 200) begin
                timeout_fail($sformatf("handshake_ch%0d", ch));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        drv.awid = id; drv.awaddr = addr; drv.awlen = len; drv.awsize = size;
        drv.awburst = burst; drv.awvalid = 1'b1;
        hs_wait(0);
        drv.awvalid = 1'b0;
    endtask

    task automatic w_send(input int n, input logic [3:0] strb, input int last_idx);
        for (int i = 0; i < n; i++) begin
            drv.wdata = wbuf[i]; drv.wstrb = strb; drv.wlast = (i == last_idx);
            drv.wvalid = 1'b1;
            hs_wait(1);
        end
        drv.wvalid = 1'b0;
        drv.wlast  = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        drv.arid = id; drv.araddr = addr; drv.arlen = len; drv.arsize = size;
        drv.arburst = burst; drv.arvalid = 1'b1;
        hs_wait(2);
        drv.arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                      input int last_idx, input logic [1:0] resp);
        bexp_t e;
        e.id = id;
        e.resp = resp;
        bq.push_back(e);
        aw_send(id, addr, len, size, burst);
        check("busy_in_write", 64'(busy), 64'd1);
        w_send(int'(len) + 1, strb, last_idx);
        drain();
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = (erb[i] == RESP_OKAY) ? ebuf[i] : 32'd0;
            e.resp = erb[i];
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
        end
        ar_send(id, addr, len, size, burst);
        drain();
    endtask

    task automatic fill_resp(input logic [1:0] r);
        for (int i = 0; i < 16; i++) erb[i] = r;
    endtask

    task automatic rready_drv();
        forever begin
            @(posedge clk);
            #1;
            rready_tb = rtog ? ~rready_tb : 1'b1;
        end
    endtask

    task automatic monitor();
        rexp_t re;
        bexp_t be;
        logic held_v = 1'b0;
        logic [38:0] held = '0;
        logic mid = 1'b0;
        int gap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0; mid = 1'b0; gap = 0;
                continue;
            end
            if (held_v)
                check("r_stall_stable", 64'({miso.rvalid, miso.rdata, miso.rresp, miso.rlast, miso.rid}),
                      64'({1'b1, held}));
            held_v = miso.rvalid && !mosi.rready;
            held   = {miso.rdata, miso.rresp, miso.rlast, miso.rid};
            if (miso.rvalid && mid) begin
                check("r_gap", 64'(gap), 64'(exp_gap));
                mid = 1'b0;
            end
            if (!miso.rvalid && mid) gap++;
            if (miso.rvalid && mosi.rready) begin
                if (rq.size() == 0) begin
                    timeout_fail("r_unexpected_beat");
                end else begin
                    re = rq.pop_front();
                    check("r_beat", 64'({miso.rdata, miso.rresp, miso.rlast, miso.rid}), 64'(re));
                end
                mid = !miso.rlast;
                gap = 0;
            end
            if (miso.bvalid && mosi.bready) begin
                if (bq.size() == 0) begin
                    timeout_fail("b_unexpected_resp");
                end else begin
                    be = bq.pop_front();
                    check("b_resp", 64'({miso.bid, miso.bresp}), 64'(be));
                end
            end
        end
    endtask

    initial begin
        int n;
        drv = '0;
        drv.bready = 1'b1;
        fork
            monitor();
            rready_drv();
        join_none

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso0", 64'(miso0), 64'd0);
        check("rst_miso1", 64'(miso1), 64'd0);
        check("rst_busy", 64'({busy0, busy1}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("awready_before_edge", 64'(miso0.awready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'({miso0.awready, miso0.arready}), 64'h3);

        // INCR write then read back
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        wr(4'h3, 32'h100, 8'd3, 3'd2, BURST_INCR, 4'hF, 3, RESP_OKAY);
        ebuf[0] = 32'h11; ebuf[1] = 32'h22; ebuf[2] = 32'h33; ebuf[3] = 32'h44;
        fill_resp(RESP_OKAY);
        rd(4'h5, 32'h100, 8'd3, 3'd2, BURST_INCR);

        // partial strobes
        wbuf[0] = 32'hFFFF_FFFF;
        wr(4'h1, 32'h40, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, RESP_OKAY);
        wbuf[0] = 32'hAABB_CCDD;
        wr(4'h2, 32'h40, 8'd0, 3'd2, BURST_INCR, 4'b0101, 0, RESP_OKAY);
        ebuf[0] = 32'hFFBB_FFDD;
        rd(4'h2, 32'h40, 8'd0, 3'd2, BURST_INCR);

        // WRAP read and address range edges
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        wr(4'h4, 32'h30, 8'd3, 3'd2, BURST_INCR, 4'hF, 3, RESP_OKAY);
        ebuf[0] = 32'hA2; ebuf[1] = 32'hA3; ebuf[2] = 32'hA0; ebuf[3] = 32'hA1;
        rd(4'h6, 32'h38, 8'd3, 3'd2, BURST_WRAP);
        fill_resp(RESP_DECERR);
        rd(4'h7, 32'h1000, 8'd0, 3'd2, BURST_INCR);
        wbuf[0] = 32'h1234_5678;
        wr(4'h8, 32'h1000, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, RESP_DECERR);
        wbuf[0] = 32'hCAFE_F00D;
        wr(4'h9, 32'hFFC, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, RESP_OKAY);
        ebuf[0] = 32'hCAFE_F00D;
        erb[0] = RESP_OKAY; erb[1] = RESP_DECERR;
        rd(4'hA, 32'hFFC, 8'd1, 3'd2, BURST_INCR);

        // wlast misplaced, oversize beat, reserved burst, bad wrap length
        wbuf[0] = 32'h51; wbuf[1] = 32'h52; wbuf[2] = 32'h53; wbuf[3] = 32'h54;
        wr(4'h7, 32'h300, 8'd3, 3'd2, BURST_INCR, 4'hF, 1, RESP_SLVERR);
        ebuf[0] = 32'h51; ebuf[1] = 32'h52; ebuf[2] = 32'h53; ebuf[3] = 32'h54;
        fill_resp(RESP_OKAY);
        rd(4'h1, 32'h300, 8'd3, 3'd2, BURST_INCR);
        wbuf[0] = 32'hDEAD;
        wr(4'h4, 32'h300, 8'd0, 3'd3, BURST_INCR, 4'hF, 0, RESP_SLVERR);
        wbuf[0] = 32'hBAD0;
        wr(4'h5, 32'h300, 8'd0, 3'd2, 2'b11, 4'hF, 0, RESP_SLVERR);
        ebuf[0] = 32'h51;
        rd(4'h2, 32'h300, 8'd0, 3'd2, BURST_INCR);
        fill_resp(RESP_SLVERR);
        rd(4'h3, 32'h300, 8'd1, 3'd2, 2'b11);
        rd(4'h3, 32'h30, 8'd2, 3'd2, BURST_WRAP);

        // RD_WAIT=2 instance with rready toggling
        sel = 1'b1;
        exp_gap = 2;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
        wr(4'hB, 32'h200, 8'd7, 3'd2, BURST_INCR, 4'hF, 7, RESP_OKAY);
        for (int i = 0; i < 8; i++) ebuf[i] = 32'h1000 + 32'(i);
        fill_resp(RESP_OKAY);
        rtog = 1'b1;
        rd(4'hC, 32'h200, 8'd7, 3'd2, BURST_INCR);
        rtog = 1'b0;
        @(posedge clk);
        #1;
        sel = 1'b0;
        exp_gap = 0;

        // reset in the middle of a write and a read burst
        aw_send(4'h9, 32'h400, 8'd7, 3'd2, BURST_INCR);
        wbuf[0] = 32'h77;
        w_send(1, 4'hF, 99);
        ebuf[0] = 32'h11; ebuf[1] = 32'h22;
        for (int i = 0; i < 2; i++) rq.push_back({ebuf[i], RESP_OKAY, 1'b0, 4'hD});
        ar_send(4'hD, 32'h100, 8'd7, 3'd2, BURST_INCR);
        n = 0;
        while (rq.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) timeout_fail("abort_beat2");
        check("busy_before_abort", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_miso", 64'(miso0), 64'd0);
        check("abort_busy", 64'(busy0), 64'd0);
        rq.delete();
        bq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_abort", 64'({miso0.awready, miso0.arready, busy0}), 64'h6);
        ebuf[0] = 32'h77;
        fill_resp(RESP_OKAY);
        rd(4'hE, 32'h400, 8'd0, 3'd2, BURST_INCR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
